// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and helpers for the MicroEV next-PC/branch unit.
// Holds the branch condition encoding, counter init value and the counter update rule.
package branch_predict_unit_pkg;

  localparam logic [1:0] COND_UNCOND = 2'b00;
  localparam logic [1:0] BHT_INIT    = 2'b01;

  typedef logic [1:0] ctr_t;

  // Pending entry layout is {alt_pc, pred, idx}
  function automatic int entry_width(int aw, int bht_bits);
    return aw + 1 + bht_bits;
  endfunction

  function automatic ctr_t ctr_update(ctr_t c, logic taken);
    if (taken) begin
      return (c == 2'b11) ? c : c + 2'd1;
    end
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/resolve bus between the fetch stage and the branch unit.
// The master side drives instructions and resolutions; the slave side is the branch unit.
interface branch_predict_unit_if #(
  parameter int AW    = 11,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW+2:0] instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          resolve_valid;
  logic          resolve_taken;
  logic [AW-1:0] next_pc;
  logic          redirect;
  logic          stall;
  logic [CW-1:0] pending;
  logic          protocol_err;

  modport master (
    output instr, instr_valid, pc, resolve_valid, resolve_taken,
    input  next_pc, redirect, stall, pending, protocol_err
  );

  modport slave (
    input  instr, instr_valid, pc, resolve_valid, resolve_taken,
    output next_pc, redirect, stall, pending, protocol_err
  );

endinterface

// File: rtl/branch_predict_unit_fifo.sv
// In-order queue of unresolved branch predictions with push/pop/clear.
// Push on a full queue is accepted when a pop happens in the same cycle.
module pending_branch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Next-PC unit: decodes branches, predicts conditionals with 2-bit counters,
// queues predictions and recovers fetch on a mispredicted resolve.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int AW       = 11,
  parameter int DEPTH    = 4,
  parameter int BHT_BITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  branch_predict_unit_if.slave bus
);

  localparam int BHT_SIZE = 2 ** BHT_BITS;
  localparam int EW       = entry_width(AW, BHT_BITS);
  localparam int CW       = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0]       alt_pc;
    logic                pred;
    logic [BHT_BITS-1:0] idx;
  } entry_t;

  ctr_t                bht_reg [BHT_SIZE];
  logic [AW-1:0]       next_pc_reg;
  logic [AW-1:0]       next_pc_next;
  logic                redirect_reg;
  logic                protocol_err_reg;

  logic                is_branch;
  logic                is_cond;
  logic [1:0]          cond;
  logic [AW-1:0]       target;
  logic [AW-1:0]       pc_inc;
  logic [BHT_BITS-1:0] lookup_idx;
  logic                pred;
  logic                resolve_act;
  logic                mispredict;
  logic                stall;
  logic                accept;
  logic                push;
  entry_t              push_entry;
  entry_t              head;
  logic [EW-1:0]       fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  ctr_t                bht_wdata;

  pending_branch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (resolve_act),
    .clear     (mispredict),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head = entry_t'(fifo_head);

  always_comb begin
    is_branch   = bus.instr[AW+2];
    cond        = bus.instr[AW+1:AW];
    target      = bus.instr[AW-1:0];
    is_cond     = is_branch && (cond != COND_UNCOND);
    lookup_idx  = bus.pc[BHT_BITS-1:0];
    pred        = bht_reg[lookup_idx][1];
    pc_inc      = bus.pc + AW'(1);
    resolve_act = bus.resolve_valid & ~fifo_empty;
    mispredict  = resolve_act & (bus.resolve_taken != head.pred);
    // A correct resolve frees a slot this cycle, so a full queue can still accept
    stall       = bus.instr_valid & is_cond & fifo_full &
                  ~(bus.resolve_valid & ~mispredict);
    accept      = bus.instr_valid & ~stall & ~mispredict;
    push        = accept & is_cond;
    push_entry  = '{alt_pc: (pred ? pc_inc : target), pred: pred, idx: lookup_idx};
    bht_wdata   = ctr_update(bht_reg[head.idx], bus.resolve_taken);

    next_pc_next = next_pc_reg;
    if (mispredict) begin
      next_pc_next = head.alt_pc;
    end else if (accept) begin
      if (!is_branch)     next_pc_next = pc_inc;
      else if (!is_cond)  next_pc_next = target;
      else                next_pc_next = pred ? target : pc_inc;
    end
  end

  // One counter per generate slot; lookups in the update cycle see the old value
  genvar gi;
  generate
    for (gi = 0; gi < BHT_SIZE; gi++) begin : g_bht
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          bht_reg[gi] <= BHT_INIT;
        end else if (resolve_act && (head.idx == BHT_BITS'(gi))) begin
          bht_reg[gi] <= bht_wdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_pc_reg      <= '0;
      redirect_reg     <= 1'b0;
      protocol_err_reg <= 1'b0;
    end else begin
      next_pc_reg  <= next_pc_next;
      redirect_reg <= mispredict;
      if (bus.resolve_valid && fifo_empty) begin
        protocol_err_reg <= 1'b1;
      end
    end
  end

  assign bus.next_pc      = next_pc_reg;
  assign bus.redirect     = redirect_reg;
  assign bus.stall        = stall;
  assign bus.pending      = fifo_count;
  assign bus.protocol_err = protocol_err_reg;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed scenarios plus randomized traffic against a queue/array reference model
// of the branch unit; every cycle's outputs are compared with the model.
module tb_branch_predict_unit;

  localparam int AW       = 11;
  localparam int DEPTH    = 4;
  localparam int BHT_BITS = 4;
  localparam int PC_MOD   = 2 ** AW;
  localparam int BHT_N    = 2 ** BHT_BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  branch_predict_unit #(
    .AW       (AW),
    .DEPTH    (DEPTH),
    .BHT_BITS (BHT_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int alt_pc;
    bit pred;
    int idx;
  } pend_t;

  pend_t m_q[$];
  int    m_bht [BHT_N];
  int    m_npc;
  bit    m_redir;
  bit    m_perr;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  logic  obs_stall;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < BHT_N; i++) m_bht[i] = 1;
    m_npc   = 0;
    m_redir = 0;
    m_perr  = 0;
  endtask

  // One clock of stimulus: drive, check stall, advance model, check registered outputs
  task automatic step(input bit iv, input bit br, input bit [1:0] cd, input int tgt,
                      input int pcv, input bit rv, input bit rt, input bit rn);
    bit    cond_i, full, mis, stall_e, pred;
    int    idx, inc;
    pend_t h, e;
    rst_n             = rn;
    bus.instr_valid   = iv;
    bus.instr         = {br, cd, AW'(tgt)};
    bus.pc            = AW'(pcv);
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    #1;
    idx     = pcv % BHT_N;
    inc     = (pcv + 1) % PC_MOD;
    pred    = (m_bht[idx] >= 2);
    cond_i  = br && (cd != 2'b00);
    mis     = rv && (m_q.size() > 0) && (rt != m_q[0].pred);
    full    = (m_q.size() == DEPTH);
    stall_e = iv && cond_i && full && !(rv && !mis);
    obs_stall = bus.stall;
    check_val("stall", {31'b0, bus.stall}, {31'b0, stall_e});

    if (!rn) begin
      model_reset();
    end else begin
      m_redir = mis;
      if (rv && m_q.size() == 0) m_perr = 1;
      if (rv && m_q.size() > 0) begin
        h = m_q.pop_front();
        if (rt) m_bht[h.idx] = (m_bht[h.idx] == 3) ? 3 : m_bht[h.idx] + 1;
        else    m_bht[h.idx] = (m_bht[h.idx] == 0) ? 0 : m_bht[h.idx] - 1;
      end
      if (mis) begin
        m_npc = h.alt_pc;
        m_q.delete();
      end else if (iv && !stall_e) begin
        if (!br) begin
          m_npc = inc;
        end else if (!cond_i) begin
          m_npc = tgt;
        end else begin
          m_npc    = pred ? tgt : inc;
          e.alt_pc = pred ? inc : tgt;
          e.pred   = pred;
          e.idx    = idx;
          m_q.push_back(e);
        end
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    check_val("next_pc", {21'b0, bus.next_pc}, m_npc);
    check_val("redirect", {31'b0, bus.redirect}, {31'b0, m_redir});
    check_val("pending", {29'b0, bus.pending}, m_q.size());
    check_val("protocol_err", {31'b0, bus.protocol_err}, {31'b0, m_perr});
    $display("cyc %0d rst_n=%0d iv=%0d br=%0d cond=%0d pc=%03h tgt=%03h rv=%0d rt=%0d -> next_pc=%03h redirect=%0d stall=%0d pending=%0d perr=%0d",
             cyc, rn, iv, br, cd, pcv, tgt, rv, rt, bus.next_pc, bus.redirect, obs_stall,
             bus.pending, bus.protocol_err);
  endtask

  initial begin
    bit iv, br, rv, rt, rn;
    bit [1:0] cd;
    int tgt, pcv;

    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_val("rst_npc", {21'b0, bus.next_pc}, 0);
    check_val("rst_pend", {29'b0, bus.pending}, 0);

    // Sequential fetch and unconditional jump
    step(1, 0, 0, 0, 5, 0, 0, 1);
    check_val("t1_npc", {21'b0, bus.next_pc}, 6);
    check_val("t1_pend", {29'b0, bus.pending}, 0);
    step(1, 1, 0, 'h123, 6, 0, 0, 1);
    check_val("t2_npc", {21'b0, bus.next_pc}, 'h123);
    check_val("t2_pend", {29'b0, bus.pending}, 0);

    // Weakly-not-taken prediction, then a taken resolve forces recovery
    step(1, 1, 2'b01, 'h200, 'h010, 0, 0, 1);
    check_val("t3_npc", {21'b0, bus.next_pc}, 'h011);
    check_val("t3_pend", {29'b0, bus.pending}, 1);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    check_val("t3_redir", {31'b0, bus.redirect}, 1);
    check_val("t3_rec_npc", {21'b0, bus.next_pc}, 'h200);
    check_val("t3_rec_pend", {29'b0, bus.pending}, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check_val("t3_pulse", {31'b0, bus.redirect}, 0);
    step(1, 1, 2'b10, 'h300, 'h020, 0, 0, 1);
    check_val("t3_bht0_taken", {21'b0, bus.next_pc}, 'h300);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    check_val("t3_correct", {31'b0, bus.redirect}, 0);

    // Fill the queue, stall the fifth, then accept it alongside a correct resolve
    for (int i = 1; i <= DEPTH; i++) step(1, 1, 2'b11, 'h400, 'h040 + i, 0, 0, 1);
    check_val("t4_full", {29'b0, bus.pending}, DEPTH);
    step(1, 1, 2'b01, 'h500, 'h055, 0, 0, 1);
    check_val("t4_stall", {31'b0, obs_stall}, 1);
    check_val("t4_hold", {21'b0, bus.next_pc}, 'h045);
    step(1, 1, 2'b01, 'h500, 'h055, 1, 0, 1);
    check_val("t4_nostall", {31'b0, obs_stall}, 0);
    check_val("t4_pend", {29'b0, bus.pending}, DEPTH);
    check_val("t4_npc", {21'b0, bus.next_pc}, 'h056);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 1, 0, 1);
    check_val("t4_drain", {29'b0, bus.pending}, 0);

    // Saturate idx 3 upward, then one not-taken still predicts taken
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 2'b01, 'h100, 'h063, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1, 1, 1);
    end
    step(1, 1, 2'b01, 'h1AB, 'h073, 0, 0, 1);
    check_val("t5_sat_pred", {21'b0, bus.next_pc}, 'h1AB);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    check_val("t5_mis_redir", {31'b0, bus.redirect}, 1);
    check_val("t5_mis_npc", {21'b0, bus.next_pc}, 'h074);
    step(1, 1, 2'b01, 'h1CD, 'h083, 0, 0, 1);
    check_val("t5_still_taken", {21'b0, bus.next_pc}, 'h1CD);
    step(0, 0, 0, 0, 0, 1, 1, 1);

    // Resolve on an empty queue is sticky; reset clears everything mid-queue
    step(0, 0, 0, 0, 0, 1, 1, 1);
    check_val("t6_perr", {31'b0, bus.protocol_err}, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check_val("t6_perr_sticky", {31'b0, bus.protocol_err}, 1);
    step(1, 1, 2'b01, 'h222, 'h013, 0, 0, 1);
    check_val("t6_q1", {29'b0, bus.pending}, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_val("t6_rst_pend", {29'b0, bus.pending}, 0);
    check_val("t6_rst_npc", {21'b0, bus.next_pc}, 0);
    check_val("t6_rst_perr", {31'b0, bus.protocol_err}, 0);
    step(1, 1, 2'b01, 'h2AA, 'h033, 0, 0, 1);
    check_val("t6_rst_bht", {21'b0, bus.next_pc}, 'h034);

    // Randomized traffic; resolves usually agree with the queued prediction
    for (int n = 0; n < 1500; n++) begin
      iv  = ($urandom_range(0, 9) < 7);
      br  = ($urandom_range(0, 9) < 6);
      cd  = 2'($urandom_range(0, 3));
      tgt = $urandom_range(0, PC_MOD - 1);
      pcv = $urandom_range(0, PC_MOD - 1);
      rv  = ($urandom_range(0, 9) < 3);
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0) rt = m_q[0].pred;
      else rt = 1'($urandom_range(0, 1));
      rn  = ($urandom_range(0, 99) != 0);
      step(iv, br, cd, tgt, pcv, rv, rt, rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
